// File: rtl/mdu_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        en;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] C;

  modport master (
    output en, MDUOp, A, B,
    input  start, busy, HI, LO, C
  );

  modport slave (
    input  en, MDUOp, A, B,
    output start, busy, HI, LO, C
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed at issue and held pending until the fixed latency expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_t_q, hi_t_d, lo_t_q, lo_t_d;
  logic        wr_q, wr_d;

  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, sq_mag, sr_mag, sq, sr, ub, uq, ur;
  logic        is_div, div_zero;

  assign bus.start = bus.en && (bus.MDUOp inside {OpMult, OpMultu, OpDiv, OpDivu});
  assign bus.busy  = (state_q == StBusy);
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.C     = (bus.en && bus.MDUOp == OpMfhi) ? hi_q :
                     (bus.en && bus.MDUOp == OpMflo) ? lo_q : 32'h0;

  assign is_div   = (bus.MDUOp == OpDiv) || (bus.MDUOp == OpDivu);
  assign div_zero = (bus.B == 32'h0);

  always_comb begin
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'h0, bus.A} * {32'h0, bus.B};
    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 without overflow.
    a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    b_mag  = div_zero ? 32'd1 : (bus.B[31] ? (~bus.B + 32'd1) : bus.B);
    sq_mag = a_mag / b_mag;
    sr_mag = a_mag % b_mag;
    sq     = (bus.A[31] ^ bus.B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    sr     = bus.A[31] ? (~sr_mag + 32'd1) : sr_mag;
    ub     = div_zero ? 32'd1 : bus.B;
    uq     = bus.A / ub;
    ur     = bus.A % ub;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_t_d  = hi_t_q;
    lo_t_d  = lo_t_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StBusy;
          cnt_d   = is_div ? DivCnt : MultCnt;
          wr_d    = !(is_div && div_zero);
          case (bus.MDUOp)
            OpMult:  {hi_t_d, lo_t_d} = prod_s;
            OpMultu: {hi_t_d, lo_t_d} = prod_u;
            OpDiv:   {hi_t_d, lo_t_d} = {sr, sq};
            default: {hi_t_d, lo_t_d} = {ur, uq};
          endcase
        end else if (bus.en && bus.MDUOp == OpMthi) begin
          hi_d = bus.A;
        end else if (bus.en && bus.MDUOp == OpMtlo) begin
          lo_d = bus.A;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (wr_q) begin
            hi_d = hi_t_q;
            lo_d = lo_t_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      hi_t_q  <= 32'h0;
      lo_t_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_t_q  <= hi_t_d;
      lo_t_q  <= lo_t_d;
      wr_q    <= wr_d;
    end
  end

  // A start arriving while busy would be silently dropped; the hazard unit must prevent it.
  a_no_start_when_busy : assert property (@(posedge clk) disable iff (!reset)
    !(bus.start && bus.busy));

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pushed at issue, popped when busy falls.
module tb_mdu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();
  mdu dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: r = 64'(sa * sb);
      4'd2: r = {32'h0, a} * {32'h0, b};
      4'd3: r = (b == 0) ? {hi_m, lo_m} : {32'(sa % sb), 32'(sa / sb)};
      4'd4: r = (b == 0) ? {hi_m, lo_m} : {a % b, a / b};
      default: r = {hi_m, lo_m};
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the issuing edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    bus.en = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    sb_q.push_back(model(op, a, b));
    #1 check_eq({tag, ".start"}, 64'(bus.start), 64'd1);
    @(negedge clk);
    bus.en = 1'b0; bus.MDUOp = 4'd0;
  endtask

  task automatic wait_done(input int unsigned exp_cyc, input int unsigned already,
                           input string tag, output int unsigned cyc);
    logic [63:0] e;
    cyc = already;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, ".sb"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, ".hilo"}, {bus.HI, bus.LO}, e);
      {hi_m, lo_m} = e;
    end
  endtask

  task automatic read_c(input logic [3:0] op, input logic [31:0] exp, input string tag);
    bus.en = 1'b1; bus.MDUOp = op;
    #1 check_eq(tag, 64'(bus.C), 64'(exp));
    @(negedge clk);
    bus.en = 1'b0; bus.MDUOp = 4'd0;
  endtask

  task automatic write_mt(input logic [3:0] op, input logic [31:0] a);
    bus.en = 1'b1; bus.MDUOp = op; bus.A = a;
    @(negedge clk);
    bus.en = 1'b0; bus.MDUOp = 4'd0;
    if (op == 4'd7) hi_m = a; else lo_m = a;
  endtask

  int unsigned cyc, cyc2;
  logic [3:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.MDUOp = 4'd0; bus.A = 32'h0; bus.B = 32'h0;
    hi_m = 32'h0; lo_m = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst.busy", 64'(bus.busy), 64'd0);
    check_eq("rst.hilo", {bus.HI, bus.LO}, 64'd0);
    read_c(4'd5, 32'h0, "rst.mfhi");
    read_c(4'd6, 32'h0, "rst.mflo");

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    wait_done(5, 0, "mult", cyc);
    check_eq("mult.k", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    wait_done(5, 0, "multu", cyc);
    check_eq("multu.k", {bus.HI, bus.LO}, 64'h0000_0002_FFFF_FFFA);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div");
    wait_done(10, 0, "div", cyc);
    check_eq("div.k", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0, "divu0");
    wait_done(10, 0, "divu0", cyc);
    check_eq("divu0.k", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    wait_done(10, 0, "divovf", cyc);
    check_eq("divovf.k", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

    write_mt(4'd7, 32'h1234_5678);
    read_c(4'd5, 32'h1234_5678, "mthi.c");
    write_mt(4'd8, 32'h0BAD_F00D);
    read_c(4'd6, 32'h0BAD_F00D, "mtlo.c");
    check_eq("mt.hilo", {bus.HI, bus.LO}, {hi_m, lo_m});

    // MTLO ignored and MFLO returns the old LO while the divide is in flight.
    issue(4'd3, 32'd100, 32'd7, "divmt");
    bus.en = 1'b1; bus.MDUOp = 4'd8; bus.A = 32'hDEAD_BEEF;
    @(negedge clk);
    read_c(4'd6, 32'h0BAD_F00D, "busy.mflo");
    wait_done(10, 2, "divmt", cyc);
    check_eq("divmt.k", {bus.HI, bus.LO}, 64'h0000_0002_0000_000E);

    for (int i = 0; i < 6; i++) begin
      rop = 4'(1 + (i % 4));
      ra  = $urandom;
      rb  = (i == 5) ? 32'h0 : $urandom;
      issue(rop, ra, rb, "rnd");
      wait_done((rop > 4'd2) ? 10 : 5, 0, "rnd", cyc);
    end

    // Back-to-back: second start on the first idle cycle.
    issue(4'd1, 32'h0001_0000, 32'h0001_0000, "b2b1");
    wait_done(5, 0, "b2b1", cyc);
    check_eq("b2b1.k", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
    issue(4'd1, 32'hFFFF_FFFB, 32'd7, "b2b2");
    wait_done(5, 0, "b2b2", cyc2);
    check_eq("b2b.total", 64'(cyc + cyc2), 64'd10);
    check_eq("b2b2.k", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFDD);

    // Async reset at the third busy cycle of a divide.
    issue(4'd3, 32'd1000, 32'd3, "abort");
    repeat (2) @(negedge clk);
    check_eq("abort.busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("abort.busy", 64'(bus.busy), 64'd0);
    check_eq("abort.hilo", {bus.HI, bus.LO}, 64'd0);
    sb_q.delete();
    hi_m = 32'h0; lo_m = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("abort.late_busy", 64'(bus.busy), 64'd0);
    check_eq("abort.late_hilo", {bus.HI, bus.LO}, {hi_m, lo_m});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
